// File: rtl/fp_mul_iter.sv
// fp_mul_iter: multi-cycle IEEE-754 single-precision multiplier, shift-add mantissa product,
// round-to-nearest-even, flush-to-zero, fixed 26-cycle latency with valid/ready handshakes.
module fp_mul_iter (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out
);
   typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} state_t;

   state_t             state_q, state_d;
   logic        [4:0]  cnt_q, cnt_d;
   logic        [47:0] acc_q, acc_d;
   logic        [23:0] ma_q, ma_d, mb_q, mb_d;
   logic signed [9:0]  exp_q, exp_d;
   logic               sign_q, sign_d, spec_q, spec_d;
   logic        [31:0] spec_val_q, spec_val_d, out_q, out_d;
   logic        [22:0] frac_q, frac_d;
   logic               guard_q, guard_d, sticky_q, sticky_d, out_valid_q, out_valid_d;

   logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, s_in;
   logic        [23:0] rnd;
   logic signed [9:0]  e_r;

   assign a_nan  = (&a[30:23]) & (|a[22:0]);
   assign a_inf  = (&a[30:23]) & ~(|a[22:0]);
   assign a_zero = ~(|a[30:23]);
   assign b_nan  = (&b[30:23]) & (|b[22:0]);
   assign b_inf  = (&b[30:23]) & ~(|b[22:0]);
   assign b_zero = ~(|b[30:23]);
   assign s_in   = a[31] ^ b[31];

   // A rounding carry leaves rnd[22:0] all-zero, so the fraction needs no separate clear.
   assign rnd = {1'b0, frac_q} + {23'd0, guard_q & (sticky_q | frac_q[0])};
   assign e_r = exp_q + {9'd0, rnd[23]};

   assign in_ready  = (state_q == IDLE) & ~rst;
   assign out_valid = out_valid_q;
   assign out       = out_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      ma_d        = ma_q;
      mb_d        = mb_q;
      exp_d       = exp_q;
      sign_d      = sign_q;
      spec_d      = spec_q;
      spec_val_d  = spec_val_q;
      frac_d      = frac_q;
      guard_d     = guard_q;
      sticky_d    = sticky_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: if (in_valid) begin
            state_d    = MUL;
            sign_d     = s_in;
            ma_d       = {1'b1, a[22:0]};
            mb_d       = {1'b1, b[22:0]};
            exp_d      = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
            acc_d      = 48'd0;
            cnt_d      = 5'd0;
            spec_d     = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
            spec_val_d = (a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf)) ? 32'h7FC00000 :
                         (a_inf | b_inf) ? {s_in, 8'hFF, 23'h0} : {s_in, 31'h0};
         end
         MUL: begin
            acc_d   = acc_q + (mb_q[cnt_q] ? ({24'd0, ma_q} << cnt_q) : 48'd0);
            cnt_d   = cnt_q + 5'd1;
            state_d = (cnt_q == 5'd23) ? NORM : MUL;
         end
         NORM: begin
            frac_d   = acc_q[47] ? acc_q[46:24] : acc_q[45:23];
            guard_d  = acc_q[47] ? acc_q[23] : acc_q[22];
            sticky_d = acc_q[47] ? |acc_q[22:0] : |acc_q[21:0];
            exp_d    = exp_q + {9'd0, acc_q[47]};
            state_d  = ROUND;
         end
         ROUND: begin
            out_d       = spec_q ? spec_val_q :
                          (e_r >= 10'sd255) ? {sign_q, 8'hFF, 23'h0} :
                          (e_r <= 10'sd0) ? {sign_q, 31'h0} : {sign_q, e_r[7:0], rnd[22:0]};
            out_valid_d = 1'b1;
            state_d     = DONE;
         end
         DONE: if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 5'd0;
         acc_q       <= 48'd0;
         ma_q        <= 24'd0;
         mb_q        <= 24'd0;
         exp_q       <= 10'sd0;
         sign_q      <= 1'b0;
         spec_q      <= 1'b0;
         spec_val_q  <= 32'd0;
         frac_q      <= 23'd0;
         guard_q     <= 1'b0;
         sticky_q    <= 1'b0;
         out_q       <= 32'd0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         ma_q        <= ma_d;
         mb_q        <= mb_d;
         exp_q       <= exp_d;
         sign_q      <= sign_d;
         spec_q      <= spec_d;
         spec_val_q  <= spec_val_d;
         frac_q      <= frac_d;
         guard_q     <= guard_d;
         sticky_q    <= sticky_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
endmodule

// File: tb/tb_fp_mul_iter.sv
// tb_fp_mul_iter: random and directed operands checked every cycle against an integer-product
// reference model with literal expectations, latency, handshake and reset checks.
module tb_fp_mul_iter;
   logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
   logic [31:0] a = 0, b = 0, out;
   logic        in_ready, out_valid;
   logic        lit_has = 0, fin = 0;
   logic [31:0] lit_val = 0;
   int          total = 0, bad = 0, cyc = 0, tmo_req = 0, tmo_seen = 0;
   logic [31:0] expq[$];
   logic [32:0] litq[$];
   int          accq[$];
   logic        prev_rst = 1, prev_hs = 0, prev_ov = 0;

   fp_mul_iter dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
                    .out_valid(out_valid), .out_ready(out_ready), .out(out));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
      logic        s, xn, yn, xi, yi, xz, yz;
      int          ex, ey, e, sh;
      logic [47:0] p, rem, half;
      logic [24:0] q;
      s  = x[31] ^ y[31];
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      xn = (ex == 255) && (x[22:0] != 0);
      yn = (ey == 255) && (y[22:0] != 0);
      xi = (ex == 255) && (x[22:0] == 0);
      yi = (ey == 255) && (y[22:0] == 0);
      xz = (ex == 0);
      yz = (ey == 0);
      if (xn || yn || (xi && yz) || (xz && yi)) return 32'h7FC00000;
      if (xi || yi) return {s, 8'hFF, 23'h0};
      if (xz || yz) return {s, 31'h0};
      p  = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
      e  = ex + ey - 127;
      sh = p[47] ? 24 : 23;
      if (p[47]) e++;
      q    = 25'(p >> sh);
      rem  = p & ((48'd1 << sh) - 48'd1);
      half = 48'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q[24]) begin
         q = q >> 1;
         e++;
      end
      if (e >= 255) return {s, 8'hFF, 23'h0};
      if (e <= 0) return {s, 31'h0};
      return {s, 8'(e), q[22:0]};
   endfunction

   always @(negedge clk) begin
      if (tmo_req != tmo_seen) begin
         total++; bad++;
         $display("FAIL timeout: waits expired=%0d required=0", tmo_req - tmo_seen);
         tmo_seen = tmo_req;
      end
      if (rst) begin
         total++;
         if (out_valid !== 1'b0 || out !== 32'h0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset: out_valid=%b out=%h in_ready=%b required 0/00000000/0", out_valid, out, in_ready);
         end
         expq.delete(); litq.delete(); accq.delete();
         prev_rst = 1; prev_hs = 0; prev_ov = 0;
      end else begin
         if (prev_rst || prev_hs) begin
            total++;
            if (in_ready !== 1'b1) begin
               bad++;
               $display("FAIL ready_after: in_ready=%b required 1", in_ready);
            end
         end
         if (out_valid) begin
            total++;
            if (in_ready !== 1'b0) begin
               bad++;
               $display("FAIL both_high: in_ready=%b required 0 while out_valid", in_ready);
            end
            if (expq.size() == 0) begin
               total++; bad++;
               $display("FAIL spurious: out=%h with no operation pending", out);
            end else begin
               total++;
               if (out !== expq[0]) begin
                  bad++;
                  $display("FAIL result: out=%h required %h", out, expq[0]);
               end
               if (!prev_ov) begin
                  total++;
                  if (cyc - accq[0] != 26) begin
                     bad++;
                     $display("FAIL latency: got=%0d required 26", cyc - accq[0]);
                  end
               end
               if (litq[0][32]) begin
                  total++;
                  if (out !== litq[0][31:0]) begin
                     bad++;
                     $display("FAIL literal: out=%h required %h", out, litq[0][31:0]);
                  end
               end
               if (out_ready) begin
                  void'(expq.pop_front()); void'(litq.pop_front()); void'(accq.pop_front());
               end
            end
         end
         if (in_valid && in_ready) begin
            expq.push_back(model(a, b));
            litq.push_back({lit_has, lit_val});
            accq.push_back(cyc + 1);
         end
         prev_rst = 0;
         prev_hs  = out_valid & out_ready;
         prev_ov  = out_valid;
      end
      if (fin) begin
         total++;
         if (expq.size() != 0) begin
            bad++;
            $display("FAIL pending: results outstanding=%0d required 0", expq.size());
         end
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
   end

   task automatic op(input logic [31:0] x, input logic [31:0] y, input logic h, input logic [31:0] l,
                     input int hold, input logic junk);
      int t;
      t = 0;
      while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
      if (t == 100) tmo_req++;
      a = x; b = y; lit_has = h; lit_val = l; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      t = 0;
      while (!out_valid && t < 100) begin @(posedge clk); #1; t++; end
      if (t == 100) tmo_req++;
      repeat (hold) begin
         in_valid = junk; a = $urandom; b = $urandom;
         @(posedge clk); #1;
      end
      in_valid = 0; out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
   endtask

   function automatic logic [31:0] rnd_fp(input int kind);
      logic [31:0] v;
      v = $urandom;
      if (kind == 1) v[30:23] = 8'($urandom_range(100, 154));
      if (kind == 2) v[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      if (kind == 3) v[30:23] = 8'($urandom_range(60, 66));
      if (kind == 4) v[30:23] = 8'($urandom_range(189, 193));
      return v;
   endfunction

   initial begin
      int t;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(posedge clk); #1;
      op(32'h40400000, 32'h40000000, 1, 32'h40C00000, 0, 0);
      op(32'h3FC00000, 32'hBFC00000, 1, 32'hC0100000, 1, 0);
      op(32'h3F800001, 32'h3F800001, 1, 32'h3F800002, 0, 0);
      op(32'h3F800001, 32'h3F800003, 1, 32'h3F800004, 0, 0);
      op(32'h3F800000, 32'h3F800000, 1, 32'h3F800000, 0, 0);
      op(32'h7F800000, 32'h00000000, 1, 32'h7FC00000, 0, 0);
      op(32'h7FC00001, 32'h3F800000, 1, 32'h7FC00000, 0, 0);
      op(32'hFF800000, 32'h40000000, 1, 32'hFF800000, 0, 0);
      op(32'h00400000, 32'h40000000, 1, 32'h00000000, 0, 0);
      op(32'h7F7FFFFF, 32'h40000000, 1, 32'h7F800000, 0, 0);
      op(32'h00800000, 32'h00800000, 1, 32'h00000000, 0, 0);
      op(32'h80800000, 32'h00800000, 1, 32'h80000000, 0, 0);
      op(32'h3F800000, 32'h7F7FFFFF, 1, 32'h7F7FFFFF, 0, 0);
      op(32'h3FFFFFFF, 32'h3FFFFFFF, 1, 32'h407FFFFE, 0, 0);
      op(32'h40400000, 32'hC0000000, 1, 32'hC0C00000, 10, 1);
      t = 0;
      while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
      if (t == 100) tmo_req++;
      a = 32'h40400000; b = 32'h40400000; lit_has = 0; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      repeat (9) @(posedge clk);
      #1 rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      op(32'h40A00000, 32'h40400000, 1, 32'h41700000, 0, 0);
      for (int i = 0; i < 60; i++)
         op(rnd_fp(i % 5), rnd_fp((i / 5) % 5), 0, 32'h0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      fin = 1;
      @(posedge clk);
      repeat (3) @(posedge clk);
      $display("FAIL finish: summary not reached");
      $fatal(1);
   end
endmodule
